// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, feature-map dimensions, FSM state type
// and element helpers for the ConV1 -> MaxPool1 datapath.
package nn_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam int CONV1_W = 48;
    localparam int CONV1_H = 48;
    localparam int CONV1_C = 8;

    localparam int MP1_W = CONV1_W / 2;
    localparam int MP1_H = CONV1_H / 2;
    localparam int MP1_C = CONV1_C;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } mp_state_t;

    typedef logic signed [DATA_W-1:0] elem_t;

    function automatic elem_t smax(input elem_t a, input elem_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// maxpool_addr_gen: c/oy/ox/k scan counters producing the input read
// address, window first/last tags and the pooled output address.
module maxpool_addr_gen #(
    parameter int IN_W   = 48,
    parameter int IN_H   = 48,
    parameter int CH     = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_first_o,
    output logic              rd_last_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              run_last_o
);
    import nn_pkg::*;

    localparam int OW = IN_W / 2;
    localparam int OH = IN_H / 2;

    localparam logic [ADDR_W-1:0] IW_A   = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] IP_A   = ADDR_W'(IN_W * IN_H);
    localparam logic [ADDR_W-1:0] OW_A   = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] OP_A   = ADDR_W'(OW * OH);
    localparam logic [ADDR_W-1:0] OX_MAX = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] OY_MAX = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] C_MAX  = ADDR_W'(CH - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] ox_q, ox_d;
    logic [ADDR_W-1:0] oy_q, oy_d;
    logic [ADDR_W-1:0] c_q, c_d;

    logic k_end, ox_end, oy_end, c_end;

    assign k_end  = (k_q == 2'd3);
    assign ox_end = (ox_q == OX_MAX);
    assign oy_end = (oy_q == OY_MAX);
    assign c_end  = (c_q == C_MAX);

    always_comb begin
        k_d  = k_q;
        ox_d = ox_q;
        oy_d = oy_q;
        c_d  = c_q;
        if (clr_i) begin
            k_d  = 2'd0;
            ox_d = '0;
            oy_d = '0;
            c_d  = '0;
        end else if (step_i) begin
            k_d = k_q + 2'd1;
            if (k_end) begin
                ox_d = ox_q + ONE;
                if (ox_end) begin
                    ox_d = '0;
                    oy_d = oy_q + ONE;
                    if (oy_end) begin
                        oy_d = '0;
                        c_d  = c_end ? '0 : c_q + ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q  <= 2'd0;
            ox_q <= '0;
            oy_q <= '0;
            c_q  <= '0;
        end else begin
            k_q  <= k_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            c_q  <= c_d;
        end
    end

    // k[1] selects the window row, k[0] the column
    assign rd_addr_o = c_q * IP_A
                     + ((oy_q << 1) + ADDR_W'(k_q[1])) * IW_A
                     + (ox_q << 1) + ADDR_W'(k_q[0]);

    assign wr_addr_o  = c_q * OP_A + oy_q * OW_A + ox_q;
    assign rd_first_o = (k_q == 2'd0);
    assign rd_last_o  = k_end;
    assign run_last_o = k_end & ox_end & oy_end & c_end;

endmodule

// File: rtl/maxpool1_engine.sv
// maxpool1_engine: 2x2 stride-2 signed max-pool from the ConV1 buffer
// into the MaxPool1 buffer, launched by a rising edge on start.
module maxpool1_engine #(
    parameter int IN_W   = nn_pkg::CONV1_W,
    parameter int IN_H   = nn_pkg::CONV1_H,
    parameter int CH     = nn_pkg::CONV1_C,
    parameter int DATA_W = nn_pkg::DATA_W,
    parameter int ADDR_W = nn_pkg::ADDR_W,
    parameter int RD_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              in_ram_en,
    output logic [ADDR_W-1:0] in_ram_addr,
    input  logic [DATA_W-1:0] in_ram_data,
    output logic              out_ram_we,
    output logic [ADDR_W-1:0] out_ram_addr,
    output logic [DATA_W-1:0] out_ram_data,
    output logic              busy,
    output logic              done
);
    import nn_pkg::*;

    mp_state_t state_q, state_d;
    logic      start_q;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      start_edge;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_first;
    logic              rd_last;
    logic [ADDR_W-1:0] wr_addr;
    logic              run_last;

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] fst_q;
    logic [RD_LAT-1:0] lst_q;
    logic [ADDR_W-1:0] oad_q [RD_LAT];

    elem_t             acc_q;
    elem_t             rd_data;
    elem_t             win_max;
    logic              tail_vld;
    logic              tail_fst;
    logic              tail_lst;

    logic              out_we_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;

    assign start_edge = start & ~start_q;
    assign rd_en      = (state_q == S_READ);

    maxpool_addr_gen #(
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .CH     (CH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .clr_i      ((state_q == S_IDLE) & start_edge),
        .step_i     (rd_en),
        .rd_addr_o  (rd_addr),
        .rd_first_o (rd_first),
        .rd_last_o  (rd_last),
        .wr_addr_o  (wr_addr),
        .run_last_o (run_last)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_READ: begin
                if (run_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // only the final write can occur with the tag line empty
                if (out_we_q && !(|vld_q)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
            for (int i = 0; i < RD_LAT; i++) oad_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_en;
            fst_q[0] <= rd_first;
            lst_q[0] <= rd_last;
            oad_q[0] <= wr_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                fst_q[i] <= fst_q[i-1];
                lst_q[i] <= lst_q[i-1];
                oad_q[i] <= oad_q[i-1];
            end
        end
    end

    assign tail_vld = vld_q[RD_LAT-1];
    assign tail_fst = fst_q[RD_LAT-1];
    assign tail_lst = lst_q[RD_LAT-1];
    assign rd_data  = in_ram_data;
    assign win_max  = smax(acc_q, rd_data);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            if (tail_vld) acc_q <= tail_fst ? rd_data : win_max;
            out_we_q <= tail_vld & tail_lst;
            if (tail_vld && tail_lst) begin
                out_addr_q <= oad_q[RD_LAT-1];
                out_data_q <= win_max;
            end
        end
    end

    assign in_ram_en    = rd_en;
    assign in_ram_addr  = rd_en ? rd_addr : '0;
    assign out_ram_we   = out_we_q;
    assign out_ram_addr = out_addr_q;
    assign out_ram_data = out_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_maxpool1_engine.sv
// tb_maxpool1_engine: randomized runs against a window-max reference,
// with a queue scoreboard checked by an independent write monitor.
module tb_maxpool1_engine;

    localparam int IN_W   = 48;
    localparam int IN_H   = 48;
    localparam int CH     = 8;
    localparam int RD_LAT = 2;
    localparam int OW     = IN_W / 2;
    localparam int OH     = IN_H / 2;
    localparam int N_IN   = IN_W * IN_H * CH;
    localparam int N_OUT  = OW * OH * CH;
    localparam int DONE_C = 18434 + RD_LAT;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        in_ram_en;
    logic [15:0] in_ram_addr;
    logic [7:0]  in_ram_data;
    logic        out_ram_we;
    logic [15:0] out_ram_addr;
    logic [7:0]  out_ram_data;
    logic        busy;
    logic        done;

    always #5 sys_clk = ~sys_clk;

    maxpool1_engine #(
        .IN_W   (IN_W),
        .IN_H   (IN_H),
        .CH     (CH),
        .DATA_W (8),
        .ADDR_W (16),
        .RD_LAT (RD_LAT)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_ram_en    (in_ram_en),
        .in_ram_addr  (in_ram_addr),
        .in_ram_data  (in_ram_data),
        .out_ram_we   (out_ram_we),
        .out_ram_addr (out_ram_addr),
        .out_ram_data (out_ram_data),
        .busy         (busy),
        .done         (done)
    );

    logic signed [7:0] in_mem [N_IN];
    logic [7:0]        rd_p [RD_LAT];

    always @(posedge sys_clk) begin
        if (in_ram_en && int'(in_ram_addr) < N_IN) rd_p[0] <= in_mem[in_ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_p[i] <= rd_p[i-1];
    end
    assign in_ram_data = rd_p[RD_LAT-1];

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;
    int start_cyc = 0;
    int first_wr  = -1;
    int nwr       = 0;
    int wcount [N_OUT];
    int out_mem [N_OUT];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_max(input int c, input int oy, input int ox);
        int m;
        int v;
        m = -1000;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = in_mem[c*IN_H*IN_W + (2*oy+dy)*IN_W + 2*ox + dx];
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic push_expected();
        q.delete();
        for (int c = 0; c < CH; c++)
            for (int oy = 0; oy < OH; oy++)
                for (int ox = 0; ox < OW; ox++)
                    q.push_back('{addr: c*OH*OW + oy*OW + ox,
                                  data: ref_max(c, oy, ox)});
    endtask

    always @(negedge sys_clk) begin
        if (rst_n && out_ram_we) begin
            exp_t e;
            nwr++;
            if (first_wr < 0) first_wr = cyc - start_cyc;
            if (int'(out_ram_addr) < N_OUT) begin
                wcount[out_ram_addr]++;
                out_mem[out_ram_addr] = int'($signed(out_ram_data));
            end
            if (q.size() == 0) begin
                check("spurious_write_addr", int'(out_ram_addr), -1);
            end else begin
                e = q.pop_front();
                check("wr_addr", int'(out_ram_addr), e.addr);
                check("wr_data", int'($signed(out_ram_data)), e.data);
            end
        end
    end

    task automatic launch();
        @(negedge sys_clk);
        for (int i = 0; i < N_OUT; i++) begin
            wcount[i]  = 0;
            out_mem[i] = 0;
        end
        first_wr = -1;
        nwr      = 0;
        push_expected();
        start     = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_full(input bit glitch, input string tag);
        int dcyc;
        int gaps;
        int bad;
        dcyc = -1;
        gaps = 0;
        launch();
        @(negedge sys_clk);
        check({tag, "_busy_c1"}, int'(busy), 1);
        check({tag, "_done_c1"}, int'(done), 0);
        for (int i = 2; i < 20000 && dcyc < 0; i++) begin
            @(negedge sys_clk);
            if (glitch && i == 100) start = 1'b0;
            if (glitch && i == 101) start = 1'b1;
            if (done) dcyc = cyc - start_cyc;
            else if (!busy) gaps++;
        end
        check({tag, "_done_cycle"}, dcyc, DONE_C);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_busy_gaps"}, gaps, 0);
        check({tag, "_first_wr_cycle"}, first_wr, 5 + RD_LAT);
        check({tag, "_write_count"}, nwr, N_OUT);
        bad = 0;
        for (int i = 0; i < N_OUT; i++) if (wcount[i] != 1) bad++;
        check({tag, "_addr_not_once"}, bad, 0);
        check({tag, "_queue_left"}, q.size(), 0);
    endtask

    task automatic set_window(input int ox, input int v0, input int v1,
                              input int v2, input int v3);
        in_mem[2*ox]          = 8'(v0);
        in_mem[2*ox + 1]      = 8'(v1);
        in_mem[IN_W + 2*ox]   = 8'(v2);
        in_mem[IN_W + 2*ox+1] = 8'(v3);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_in_ram_en", int'(in_ram_en), 0);
        check("rst_in_ram_addr", int'(in_ram_addr), 0);
        check("rst_out_ram_we", int'(out_ram_we), 0);
        check("rst_out_ram_addr", int'(out_ram_addr), 0);
        check("rst_out_ram_data", int'(out_ram_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'((i % 256) - 128);
        run_full(1'b0, "ramp");

        for (int i = 0; i < N_IN; i++) in_mem[i] = 8'($urandom);
        set_window(0, 5, -3, -3, -3);
        set_window(1, -3, 5, -3, -3);
        set_window(2, -3, -3, 5, -3);
        set_window(3, -3, -3, -3, 5);
        set_window(4, -128, -128, -128, -127);
        set_window(5, -128, -128, -128, -128);

        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        launch();
        while (cyc - start_cyc < 5000) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_ram_we", int'(out_ram_we), 0);
        check("abort_out_ram_data", int'(out_ram_data), 0);
        check("abort_out_ram_addr", int'(out_ram_addr), 0);
        check("abort_in_ram_en", int'(in_ram_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        q.delete();
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        nwr = 0;
        repeat (20) @(negedge sys_clk);
        check("writes_after_abort", nwr, 0);

        run_full(1'b1, "glitch");
        check("win_pos0", out_mem[0], 5);
        check("win_pos1", out_mem[1], 5);
        check("win_pos2", out_mem[2], 5);
        check("win_pos3", out_mem[3], 5);
        check("win_neg127", out_mem[4], -127);
        check("win_neg128", out_mem[5], -128);

        repeat (50) @(negedge sys_clk);
        check("held_start_done", int'(done), 1);
        check("held_start_busy", int'(busy), 0);
        check("held_start_writes", nwr, N_OUT);

        start = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("done_held_idle", int'(done), 1);
        run_full(1'b0, "rerun");
        check("rerun_pos0", out_mem[0], 5);
        check("rerun_neg128", out_mem[5], -128);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/maxpool1_engine.md
# maxpool1_engine

2×2 / stride-2 signed max-pool stage between the ConV1 output buffer and the MaxPool1 result buffer. Once ConV1 has written its 48×48×8 int8 feature map, this block reads it through a synchronous BRAM read port, takes the signed maximum of each non-overlapping 2×2 window, and writes the 24×24×8 int8 result (4608 bytes) to the MaxPool1 BRAM. The testbench then reads that BRAM back through the read-back port. Control uses a start/done handshake driven by the block-design wrapper.

## Interface
Parameters:
- IN_W, 48, input feature-map width; must be even.
- IN_H, 48, input feature-map height; must be even.
- CH, 8, number of channels.
- DATA_W, 8, signed element width.
- ADDR_W, 16, BRAM address width.
- RD_LAT, 2, input BRAM read latency in cycles; must be ≥1.

Ports:
- sys_clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level from upstream done (end_ConV1); its rising edge launches a run.
- in_ram_en  out  1  input BRAM read enable.
- in_ram_addr  out  ADDR_W  input read address.
- in_ram_data  in  DATA_W  signed read data, valid RD_LAT cycles after en.
- out_ram_we  out  1  output BRAM write enable; one-cycle pulse per result.
- out_ram_addr  out  ADDR_W  output write address.
- out_ram_data  out  DATA_W  signed pooled value.
- busy  out  1  high from the cycle after the start edge until done rises.
- done  out  1  level; held high until the next start rising edge.

## Operation
- Memory layout, channel-major, for both buffers:
  - input address = c·IN_H·IN_W + y·IN_W + x
  - output address = c·(IN_H/2)·(IN_W/2) + oy·(IN_W/2) + ox
- Scan order: c outermost, then oy, then ox.
- Each window reads 4 elements in the order (2oy,2ox), (2oy,2ox+1), (2oy+1,2ox), (2oy+1,2ox+1).
- States:
  - IDLE: waits for a start rising edge (start=1 with registered start_d=0). Moves to READ and clears done.
  - READ: issues one read per cycle, back to back, IN_W·IN_H·CH reads in total. After the last read, moves to DRAIN.
  - DRAIN: waits until the final write has issued, then moves to DONE.
  - DONE: done=1; the next cycle returns to IDLE with done held.
- Each read carries a tag (first, last) through an RD_LAT-deep shift register.
  - On first: acc ← data.
  - Otherwise: acc ← max(acc, data), as a signed comparison.
  - On last: a registered write of max(acc, data) to the current output address.
- Output values are always an input element. No saturation or rescaling.
- A start edge while busy is ignored. Start held high after done does not retrigger.
- Reset mid-run aborts the run. There is no partial-state resume, and the output buffer contents are undefined.
- Reset values: in_ram_en=0, in_ram_addr=0, out_ram_we=0, out_ram_addr=0, out_ram_data=0, busy=0, done=0, FSM=IDLE, all counters 0.

## Timing
- Cycle 0 is the cycle in which the start edge is sampled.
- Window k is read in cycles 4k+1 … 4k+4.
- Its out_ram_we pulse is in cycle 4k+5+RD_LAT. With RD_LAT=2 the first write is at cycle 7.
- Throughput: one result every 4 cycles, with no bubbles between windows, rows or channels.
- Last write (k=4607) is at cycle 18433+RD_LAT. done rises in the following cycle: 18436 for RD_LAT=2.
- busy covers cycles 1 … done−1.
- No write ever coincides with a read of the same buffer. Input and output buffers are separate.

## Structure
- Shared package nn_pkg holds:
  - DATA_W, ADDR_W
  - the feature-map dimension constants for ConV1 and MaxPool1
  - the FSM state enum
  - a signed-max function
- Sub-module maxpool_addr_gen holds the nested c/oy/ox/k counters. It produces in_ram_addr and the first/last tags for the read in flight, plus the output address.
- The top level contains the FSM, the tag/address delay line and the accumulator.

## Test plan
- Ramp: input[i] = (i mod 256) − 128, then one run. Every output must equal the golden max and addresses 0–4607 must each be written exactly once. Check the first write at cycle 7 and done at cycle 18436.
- Max position: four windows with the max (+5) placed at each of the 4 positions and the other elements at −3. The outputs are all 5.
- Negative extremes: a window of {−128, −128, −128, −127} gives −127. A window of all −128 gives −128, which checks signed comparison.
- Reset at cycle 5000: rst_n pulsed low. The outputs are zero immediately, with no further writes. A fresh start edge then gives a full correct run.
- Start glitch: start toggled low/high at cycle 100 during busy. There is no restart and the write count stays 4608.
- Back-to-back: start held high after done gives no second run. Dropping start and raising it again gives a second identical run, with done low from the cycle after that edge.
